// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam int WORD_WIDTH  = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [WORD_WIDTH-1:0] NOP_ENCODING     = 32'h0000_0000;
    localparam logic [WORD_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        REDIRECT
    } fetch_mode_e;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] instr;
        logic                  valid;
    } if_id_t;

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// Fetch-to-decode pipeline register with load enable and synchronous flush.
module if_id_reg
    import instruction_fetch_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [WORD_WIDTH-1:0] fetch_pc,
    input  logic [WORD_WIDTH-1:0] fetch_instr,
    input  logic                  fetch_valid,
    output logic [WORD_WIDTH-1:0] pc,
    output logic [WORD_WIDTH-1:0] instr,
    output logic                  valid
);

    // Flush takes precedence over load so a redirect always injects a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (clr) begin
            pc    <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (en) begin
            pc    <= fetch_pc;
            instr <= fetch_instr;
            valid <= fetch_valid;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID register.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [WORD_WIDTH-1:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [WORD_WIDTH-1:0] branch_addr,
    output logic [WORD_WIDTH-1:0] imem_addr,
    input  logic [WORD_WIDTH-1:0] imem_instr,
    output logic [WORD_WIDTH-1:0] pc_out,
    output logic [WORD_WIDTH-1:0] instr_out,
    output logic                  valid_out
);

    fetch_mode_e           mode;
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] pc_plus4;
    logic [WORD_WIDTH-1:0] next_pc;
    if_id_t                fetched;

    // A redirect beats a stall: the stalled instruction is on the wrong path.
    always_comb begin
        mode = RUN;
        if (branch_taken) begin
            mode = REDIRECT;
        end else if (freeze) begin
            mode = HOLD;
        end
    end

    assign pc_plus4 = pc + WORD_WIDTH'(INSTR_BYTES);

    always_comb begin
        next_pc = pc;
        unique case (mode)
            RUN:      next_pc = pc_plus4;
            HOLD:     next_pc = pc;
            REDIRECT: next_pc = {branch_addr[WORD_WIDTH-1:2], 2'b00};
            default:  next_pc = pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= {RESET_PC[WORD_WIDTH-1:2], 2'b00};
        end else begin
            pc <= next_pc;
        end
    end

    assign imem_addr = pc;

    assign fetched = '{pc: pc_plus4, instr: imem_instr, valid: 1'b1};

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk         (clk),
        .rst         (rst),
        .en          (mode == RUN),
        .clr         (mode == REDIRECT),
        .fetch_pc    (fetched.pc),
        .fetch_instr (fetched.instr),
        .fetch_valid (fetched.valid),
        .pc          (pc_out),
        .instr       (instr_out),
        .valid       (valid_out)
    );

endmodule
